// File: rtl/uart_cmd_parser_if.sv
// +----------------------------------------------------------------------+
// | uart_cmd_parser_if : receive-side byte stream and register outputs     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface uart_cmd_parser_if;
   logic       rxDataReady;
   logic [7:0] rxData;
   logic       tick;
   logic [1:0] ledCtrl;
   logic [7:0] reportPeriod;
   logic       reportReq;
   logic       cmdValid;
   logic [7:0] cmdCode;
   logic [7:0] cmdArg;
   logic       errPulse;
   logic [7:0] errCount;

   modport master (
      output rxDataReady, rxData, tick,
      input  ledCtrl, reportPeriod, reportReq, cmdValid,
      input  cmdCode, cmdArg, errPulse, errCount
   );

   modport slave (
      input  rxDataReady, rxData, tick,
      output ledCtrl, reportPeriod, reportReq, cmdValid,
      output cmdCode, cmdArg, errPulse, errCount
   );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_parser.sv
// +----------------------------------------------------------------------+
// | uart_cmd_parser : "$<cmd><hi><lo><CR|LF>" frame parser and registers  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_cmd_parser #(
   parameter int         TIMEOUT_TICKS = 16,
   parameter logic [7:0] PERIOD_RST    = 8'h04
) (
   input  wire                  CLK_10MHZ,
   input  wire                  nRST,
   uart_cmd_parser_if.slave     bus
);

   localparam int            CW      = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_TICKS - 1);

   localparam logic [7:0] C_DOLLAR = 8'h24;
   localparam logic [7:0] C_CR     = 8'h0D;
   localparam logic [7:0] C_LF     = 8'h0A;
   localparam logic [7:0] C_L      = 8'h4C;
   localparam logic [7:0] C_P      = 8'h50;
   localparam logic [7:0] C_R      = 8'h52;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_HI   = 3'd2,
      S_LO   = 3'd3,
      S_TERM = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    letter_q, letter_d;
   logic [7:0]    arg_q, arg_d;
   logic [1:0]    ledCtrl_q, ledCtrl_d;
   logic [7:0]    period_q, period_d;
   logic          reportReq_q, reportReq_d;
   logic          cmdValid_q, cmdValid_d;
   logic [7:0]    cmdCode_q, cmdCode_d;
   logic [7:0]    cmdArg_q, cmdArg_d;
   logic          errPulse_q, errPulse_d;
   logic [7:0]    errCount_q, errCount_d;

   function automatic logic is_hex(input logic [7:0] b);
      return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
             (b >= 8'h61 && b <= 8'h66);
   endfunction

   // Letters A-F/a-f share low nibble 1..6, so +9 maps them to 10..15.
   function automatic logic [3:0] hex_val(input logic [7:0] b);
      return b[6] ? 4'(b[3:0] + 4'd9) : b[3:0];
   endfunction

   always_ff @(posedge CLK_10MHZ) begin
      if (!nRST) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         letter_q    <= 8'h00;
         arg_q       <= 8'h00;
         ledCtrl_q   <= 2'b00;
         period_q    <= PERIOD_RST;
         reportReq_q <= 1'b0;
         cmdValid_q  <= 1'b0;
         cmdCode_q   <= 8'h00;
         cmdArg_q    <= 8'h00;
         errPulse_q  <= 1'b0;
         errCount_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         letter_q    <= letter_d;
         arg_q       <= arg_d;
         ledCtrl_q   <= ledCtrl_d;
         period_q    <= period_d;
         reportReq_q <= reportReq_d;
         cmdValid_q  <= cmdValid_d;
         cmdCode_q   <= cmdCode_d;
         cmdArg_q    <= cmdArg_d;
         errPulse_q  <= errPulse_d;
         errCount_q  <= errCount_d;
      end
   end

   logic [7:0] w_b;
   logic       w_err;
   logic       w_exec;

   always_comb begin
      w_b         = bus.rxData;
      w_err       = 1'b0;
      w_exec      = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      letter_d    = letter_q;
      arg_d       = arg_q;
      ledCtrl_d   = ledCtrl_q;
      period_d    = period_q;
      reportReq_d = 1'b0;
      cmdValid_d  = 1'b0;
      cmdCode_d   = cmdCode_q;
      cmdArg_d    = cmdArg_q;

      // A received byte takes priority over a coincident timeout expiry.
      if (bus.rxDataReady) begin
         cnt_d = '0;
         case (state_q)
            S_IDLE: begin
               if (w_b == C_DOLLAR) state_d = S_CMD;
            end
            S_CMD: begin
               if (w_b == C_L || w_b == C_P || w_b == C_R) begin
                  letter_d = w_b;
                  state_d  = S_HI;
               end else begin
                  w_err   = 1'b1;
                  state_d = (w_b == C_DOLLAR) ? S_CMD : S_IDLE;
               end
            end
            S_HI: begin
               if (is_hex(w_b)) begin
                  arg_d[7:4] = hex_val(w_b);
                  state_d    = S_LO;
               end else begin
                  w_err   = 1'b1;
                  state_d = (w_b == C_DOLLAR) ? S_CMD : S_IDLE;
               end
            end
            S_LO: begin
               if (is_hex(w_b)) begin
                  arg_d[3:0] = hex_val(w_b);
                  state_d    = S_TERM;
               end else begin
                  w_err   = 1'b1;
                  state_d = (w_b == C_DOLLAR) ? S_CMD : S_IDLE;
               end
            end
            S_TERM: begin
               if (w_b == C_CR || w_b == C_LF) begin
                  w_exec  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  w_err   = 1'b1;
                  state_d = (w_b == C_DOLLAR) ? S_CMD : S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else if (state_q != S_IDLE && bus.tick) begin
         if (cnt_q == TO_LAST) begin
            w_err   = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else if (state_q == S_IDLE) begin
         cnt_d = '0;
      end

      if (w_exec) begin
         cmdValid_d = 1'b1;
         cmdCode_d  = letter_q;
         cmdArg_d   = arg_q;
         case (letter_q)
            C_L:     ledCtrl_d   = arg_q[1:0];
            C_P:     period_d    = arg_q;
            C_R:     reportReq_d = 1'b1;
            default: ;
         endcase
      end

      errPulse_d = w_err;
      errCount_d = (w_err && errCount_q != 8'hFF) ? errCount_q + 8'd1 : errCount_q;
   end

   assign bus.ledCtrl      = ledCtrl_q;
   assign bus.reportPeriod = period_q;
   assign bus.reportReq    = reportReq_q;
   assign bus.cmdValid     = cmdValid_q;
   assign bus.cmdCode      = cmdCode_q;
   assign bus.cmdArg       = cmdArg_q;
   assign bus.errPulse     = errPulse_q;
   assign bus.errCount     = errCount_q;

endmodule

`default_nettype wire

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 16: idle ticks allowed between bytes of one frame.
REQ-002 Parameter PERIOD_RST, default 8'h04: reset value of reportPeriod.
REQ-003 CLK_10MHZ  input  1  system clock, 10 MHz; one clock; reset is synchronous, active-low.
REQ-004 nRST  input  1  synchronous active-low reset.
REQ-005 rxDataReady  input  1  one-cycle strobe from the UART receiver; rxData valid in the same cycle.
REQ-006 rxData  input  8  received byte.
REQ-007 tick  input  1  one-cycle timebase strobe for the inter-byte timeout (top drives it from timerCounter, e.g. every 409.6 us).
REQ-008 ledCtrl  output  2  LED control register, bit0 to USER_LED0, bit1 to USER_LED1.
REQ-009 reportPeriod  output  8  telemetry send-period register for the frame sender.
REQ-010 reportReq  output  1  one-cycle pulse requesting an immediate telemetry line.
REQ-011 cmdValid  output  1  one-cycle pulse when any command is accepted.
REQ-012 cmdCode  output  8  ASCII letter of the last accepted command.
REQ-013 cmdArg  output  8  argument of the last accepted command.
REQ-014 errPulse  output  1  one-cycle pulse on any framing or parse error.
REQ-015 errCount  output  8  saturating error counter.

Function
REQ-016 Frame format: '$', command letter, hex digit HI, hex digit LO, terminator CR (8'h0D) or LF (8'h0A). The arg is {HI,LO}.
REQ-017 Hex digits accepted: '0'-'9', 'A'-'F', 'a'-'f'. Any other byte in HI or LO is an error.
REQ-018 Valid command letters: 'L', 'P', 'R'. Letters are case-sensitive. Any other byte in the CMD state is an error.
REQ-019 FSM states: IDLE, CMD, HI, LO, TERM. The FSM advances only on rxDataReady.
REQ-020 IDLE: '$' moves to CMD. All other bytes are discarded silently, with no error.
REQ-021 CMD: a valid letter is latched and the FSM moves to HI. HI: a valid hex digit moves to LO. LO: a valid hex digit moves to TERM. TERM: CR or LF executes the command and returns to IDLE.
REQ-022 A '$' received in CMD, HI, LO or TERM asserts errPulse and moves to CMD, so the parser resynchronises on the new frame.
REQ-023 Any other invalid byte in CMD, HI, LO or TERM asserts errPulse and returns to IDLE.
REQ-024 Execution of 'L': ledCtrl <= arg[1:0]; arg[7:2] is ignored.
REQ-025 Execution of 'P': reportPeriod <= arg. An arg of 0 is legal and is passed through unchanged.
REQ-026 Execution of 'R': reportReq pulses; arg is ignored.
REQ-027 Every execution updates cmdCode and cmdArg and pulses cmdValid.
REQ-028 Latency: register updates and all pulses appear in the cycle after the terminator's rxDataReady cycle. Pulses last exactly 1 cycle.
REQ-029 Timeout counter: cleared on every rxDataReady and held at 0 in IDLE. Outside IDLE it increments on tick.
REQ-030 When the timeout count reaches TIMEOUT_TICKS: errPulse is asserted, the FSM returns to IDLE and the counter clears.
REQ-031 If rxDataReady and the timeout expiry fall in the same cycle, the byte wins: no timeout error is raised and the byte is processed normally.
REQ-032 errCount increments by 1 per errPulse and saturates at 8'hFF with no wrap.
REQ-033 At most one errPulse per cycle; simultaneous error causes count once.
REQ-034 All outputs are registered; there are no combinational paths from inputs to outputs.

Reset
REQ-035 While nRST=0 at a clock edge, all of the following take effect:
- FSM to IDLE
- timeout counter 0
- ledCtrl 2'b00
- reportPeriod PERIOD_RST
- cmdCode 0, cmdArg 0, errCount 0
- all pulses 0
REQ-036 Reset asserted mid-frame discards the partial frame and produces no errPulse. The next frame parses normally.

Verification
REQ-037 Bytes "$L03\r", one per 20 cycles -> ledCtrl=2'b11, cmdCode=8'h4C, cmdArg=8'h03, one cmdValid pulse 1 cycle after CR.
REQ-038 "$P1a\n" then "$R00\r" -> reportPeriod=8'h1A; exactly one reportReq pulse; cmdValid pulses twice; errCount=0.
REQ-039 "$X12\r" -> errPulse at 'X', FSM back to IDLE, errCount=1, ledCtrl/reportPeriod unchanged.
REQ-040 "$L0" then "$L01\r" -> errCount=1 (resync on second '$'), then ledCtrl=2'b01 after CR.
REQ-041 Timeout and saturation:
- "$L" then 16 ticks with no byte -> errPulse, FSM IDLE, errCount=1.
- Repeat with the 16th tick coincident with '0' -> no error, parse continues.
- Preload 255 errors then 1 more -> errCount stays 8'hFF.
REQ-042 Reset mid-frame: send "$L0", assert nRST=0 for 1 cycle, then send "$L02\r" -> ledCtrl=2'b10, errCount=0.
